eat_arbiter: RTL and testbench

EAT_ARBITER -- requirements
Module: eat_arbiter

---
 rtl/eat_arbiter_if.sv | 30 +++
 rtl/eat_arbiter.sv | 146 ++++++++++++++
 tb/tb_eat_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eat_arbiter_if.sv
// Handshake bundle between the frame logic and the eat arbiter.
// master drives frame/start/body/size and observes game state; slave is the arbiter.
interface eat_arbiter_if #(
  parameter int unsigned N_FISH  = 10,
  parameter int unsigned SIZE_W  = 9,
  parameter int unsigned SCORE_W = 8
);

  logic                     frame_start;
  logic                     start;
  logic [N_FISH-1:0]        body;
  logic [N_FISH*SIZE_W-1:0] size;
  logic [N_FISH-1:0]        alive;
  logic                     eat_valid;
  logic [3:0]               eat_winner;
  logic [3:0]               eat_loser;
  logic [SCORE_W-1:0]       score;
  logic [1:0]               state;

  modport master (
    output frame_start, start, body, size,
    input  alive, eat_valid, eat_winner, eat_loser, score, state
  );

  modport slave (
    input  frame_start, start, body, size,
    output alive, eat_valid, eat_winner, eat_loser, score, state
  );

endinterface

// File: rtl/eat_arbiter.sv
// Resolves fish-on-fish collisions per pixel: the larger of the two lowest-indexed
// overlapping live fish eats the other; tracks player score and game outcome.
module eat_arbiter #(
  parameter int unsigned      N_FISH      = 10,
  parameter int unsigned      SIZE_W      = 9,
  parameter int unsigned      SCORE_W     = 8,
  parameter logic [N_FISH-1:0] PLAYER_MASK = N_FISH'(10'b0000001111)
) (
  input logic          clk,
  input logic          rst,
  eat_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10,
    StWin  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [N_FISH-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          winner_q, winner_d;
  logic [3:0]          loser_q, loser_d;
  logic                eat_valid_q, eat_valid_d;

  logic [N_FISH-1:0]   masked;
  logic                found_i, found_j;
  logic [3:0]          idx_i, idx_j;
  logic [N_FISH-1:0]   oh_i, oh_j;
  logic [SIZE_W-1:0]   size_i, size_j;
  logic                player_i, player_j;
  logic                evt, i_wins;
  logic [3:0]          win_idx, lose_idx;
  logic [N_FISH-1:0]   lose_oh;
  logic                win_player;

  // Pick the two lowest-indexed live overlapping fish; any others wait for another pixel.
  always_comb begin
    masked   = bus.body & alive_q;
    found_i  = 1'b0;
    found_j  = 1'b0;
    idx_i    = '0;
    idx_j    = '0;
    oh_i     = '0;
    oh_j     = '0;
    size_i   = '0;
    size_j   = '0;
    player_i = 1'b0;
    player_j = 1'b0;
    for (int k = 0; k < N_FISH; k++) begin
      if (masked[k]) begin
        if (!found_i) begin
          found_i  = 1'b1;
          idx_i    = 4'(k);
          oh_i[k]  = 1'b1;
          size_i   = bus.size[k*SIZE_W +: SIZE_W];
          player_i = PLAYER_MASK[k];
        end else if (!found_j) begin
          found_j  = 1'b1;
          idx_j    = 4'(k);
          oh_j[k]  = 1'b1;
          size_j   = bus.size[k*SIZE_W +: SIZE_W];
          player_j = PLAYER_MASK[k];
        end
      end
    end
  end

  always_comb begin
    evt        = found_j && (size_i != size_j);
    i_wins     = size_i > size_j;
    win_idx    = i_wins ? idx_i : idx_j;
    lose_idx   = i_wins ? idx_j : idx_i;
    lose_oh    = i_wins ? oh_j : oh_i;
    win_player = i_wins ? player_i : player_j;
  end

  always_comb begin
    state_d     = state_q;
    alive_d     = alive_q;
    score_d     = score_q;
    winner_d    = winner_q;
    loser_d     = loser_q;
    eat_valid_d = 1'b0;

    unique case (state_q)
      StPlay: begin
        if (evt) begin
          alive_d     = alive_q & ~lose_oh;
          eat_valid_d = 1'b1;
          winner_d    = win_idx;
          loser_d     = lose_idx;
          if (win_player && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
        // Exit check sees this edge's kill, so a same-cycle eat can end the game.
        if (bus.frame_start) begin
          if ((alive_d & PLAYER_MASK) == '0) begin
            state_d = StOver;
          end else if ((alive_d & ~PLAYER_MASK) == '0) begin
            state_d = StWin;
          end
        end
      end
      StIdle, StOver, StWin: begin
        if (bus.start) begin
          state_d  = StPlay;
          alive_d  = '1;
          score_d  = '0;
          winner_d = '0;
          loser_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      alive_q     <= '1;
      score_q     <= '0;
      winner_q    <= '0;
      loser_q     <= '0;
      eat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      score_q     <= score_d;
      winner_q    <= winner_d;
      loser_q     <= loser_d;
      eat_valid_q <= eat_valid_d;
    end
  end

  assign bus.alive      = alive_q;
  assign bus.eat_valid  = eat_valid_q;
  assign bus.eat_winner = winner_q;
  assign bus.eat_loser  = loser_q;
  assign bus.score      = score_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_eat_arbiter.sv
// Scenario bench for eat_arbiter: 4 fish, players 0 and 1, expected eats queued as driven.
module tb_eat_arbiter;

  localparam int unsigned NF = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [3:0] w;
    logic [3:0] l;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  eat_arbiter_if #(.N_FISH(NF), .SIZE_W(SW), .SCORE_W(CW)) bus ();

  eat_arbiter #(
    .N_FISH     (NF),
    .SIZE_W     (SW),
    .SCORE_W    (CW),
    .PLAYER_MASK(4'b0011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_sizes(input int s0, input int s1, input int s2, input int s3);
    bus.size = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endtask

  task automatic restart();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Queue the expected eat, drive one body cycle, then wait (bounded) for eat_valid.
  task automatic play_event(input logic [3:0] pat, input logic [3:0] ew, input logic [3:0] el,
                            output bit seen, output logic [3:0] gw, output logic [3:0] gl);
    exp_q.push_back('{w: ew, l: el});
    bus.body = pat;
    tick();
    bus.body = '0;
    seen = 1'b0;
    gw   = 4'hx;
    gl   = 4'hx;
    for (int c = 0; c < 4; c++) begin
      if (bus.eat_valid) begin
        seen = 1'b1;
        gw   = bus.eat_winner;
        gl   = bus.eat_loser;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.alive !== 4'b1111 || bus.eat_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%b alive=%b eat_valid=%b, want 00 1111 0",
               bus.state, bus.alive, bus.eat_valid);
    end
    checks++;
    if (bus.eat_winner !== 4'd0 || bus.eat_loser !== 4'd0 || bus.score !== 4'd0) begin
      failures++;
      $display("FAIL reset_idx: winner=%0d loser=%0d score=%0d, want 0 0 0",
               bus.eat_winner, bus.eat_loser, bus.score);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_eat();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    set_sizes(10, 12, 13, 14);
    restart();
    checks++;
    if (bus.state !== 2'b01) begin
      failures++;
      $display("FAIL start_to_play: state=%b want 01", bus.state);
    end
    play_event(4'b0011, 4'd1, 4'd0, seen, gw, gl);
    e = exp_q.pop_front();
    checks++;
    if (!seen || gw !== e.w || gl !== e.l) begin
      failures++;
      $display("FAIL basic_eat: seen=%0b w=%0d l=%0d, want w=%0d l=%0d", seen, gw, gl, e.w, e.l);
    end
    checks++;
    if (bus.alive !== 4'b1110 || bus.score !== 4'd1) begin
      failures++;
      $display("FAIL basic_state: alive=%b score=%0d, want 1110 1", bus.alive, bus.score);
    end
    tick();
    checks++;
    if (bus.eat_valid !== 1'b0) begin
      failures++;
      $display("FAIL eat_one_cycle: eat_valid=%b want 0", bus.eat_valid);
    end
    // start during play must not restart
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 2'b01 || bus.alive !== 4'b1110 || bus.score !== 4'd1) begin
      failures++;
      $display("FAIL start_in_play: state=%b alive=%b score=%0d, want 01 1110 1",
               bus.state, bus.alive, bus.score);
    end
  endtask

  task automatic test_lowest_two();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    set_sizes(20, 12, 13, 14);
    restart();
    play_event(4'b1101, 4'd0, 4'd2, seen, gw, gl);
    e = exp_q.pop_front();
    checks++;
    if (!seen || gw !== e.w || gl !== e.l) begin
      failures++;
      $display("FAIL lowest_two: seen=%0b w=%0d l=%0d, want w=%0d l=%0d", seen, gw, gl, e.w, e.l);
    end
    checks++;
    if (bus.alive !== 4'b1011 || bus.score !== 4'd1) begin
      failures++;
      $display("FAIL lowest_two_state: alive=%b score=%0d, want 1011 1", bus.alive, bus.score);
    end
  endtask

  task automatic test_equal_sizes();
    set_sizes(13, 13, 5, 5);
    restart();
    bus.body = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.eat_valid !== 1'b0) begin
        failures++;
        $display("FAIL equal_no_event: cycle=%0d eat_valid=%b want 0", c, bus.eat_valid);
      end
    end
    bus.body = '0;
    checks++;
    if (bus.alive !== 4'b1111 || bus.score !== 4'd0) begin
      failures++;
      $display("FAIL equal_state: alive=%b score=%0d, want 1111 0", bus.alive, bus.score);
    end
  endtask

  task automatic test_over();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    logic [3:0] pats [2] = '{4'b0101, 4'b0110};
    logic [3:0] wins [2] = '{4'd2, 4'd2};
    logic [3:0] loss [2] = '{4'd0, 4'd1};
    set_sizes(10, 12, 13, 14);
    restart();
    for (int k = 0; k < 2; k++) begin
      play_event(pats[k], wins[k], loss[k], seen, gw, gl);
      e = exp_q.pop_front();
      checks++;
      if (!seen || gw !== e.w || gl !== e.l) begin
        failures++;
        $display("FAIL over_eat%0d: seen=%0b w=%0d l=%0d, want w=%0d l=%0d",
                 k, seen, gw, gl, e.w, e.l);
      end
    end
    checks++;
    if (bus.state !== 2'b01 || bus.alive !== 4'b1100 || bus.score !== 4'd0) begin
      failures++;
      $display("FAIL over_pre_frame: state=%b alive=%b score=%0d, want 01 1100 0",
               bus.state, bus.alive, bus.score);
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    checks++;
    if (bus.state !== 2'b10) begin
      failures++;
      $display("FAIL over_state: state=%b want 10", bus.state);
    end
    bus.body = 4'b1100;
    tick();
    tick();
    bus.body = '0;
    checks++;
    if (bus.eat_valid !== 1'b0 || bus.alive !== 4'b1100 || bus.eat_winner !== 4'd2) begin
      failures++;
      $display("FAIL over_hold: eat_valid=%b alive=%b winner=%0d, want 0 1100 2",
               bus.eat_valid, bus.alive, bus.eat_winner);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 2'b01 || bus.alive !== 4'b1111 || bus.score !== 4'd0 ||
        bus.eat_winner !== 4'd0 || bus.eat_loser !== 4'd0) begin
      failures++;
      $display("FAIL over_restart: state=%b alive=%b score=%0d w=%0d l=%0d, want 01 1111 0 0 0",
               bus.state, bus.alive, bus.score, bus.eat_winner, bus.eat_loser);
    end
  endtask

  task automatic test_frame_collision();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    set_sizes(10, 12, 13, 14);
    restart();
    play_event(4'b0101, 4'd2, 4'd0, seen, gw, gl);
    e = exp_q.pop_front();
    checks++;
    if (!seen || gw !== e.w || gl !== e.l) begin
      failures++;
      $display("FAIL frame_pre_eat: seen=%0b w=%0d l=%0d, want w=%0d l=%0d",
               seen, gw, gl, e.w, e.l);
    end
    // last player dies on the same edge as frame_start
    bus.body        = 4'b0110;
    bus.frame_start = 1'b1;
    tick();
    bus.body        = '0;
    bus.frame_start = 1'b0;
    checks++;
    if (bus.state !== 2'b10 || bus.alive !== 4'b1100 || bus.eat_valid !== 1'b1 ||
        bus.eat_loser !== 4'd1) begin
      failures++;
      $display("FAIL frame_collision: state=%b alive=%b eat_valid=%b loser=%0d, want 10 1100 1 1",
               bus.state, bus.alive, bus.eat_valid, bus.eat_loser);
    end
  endtask

  task automatic test_win();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    logic [3:0] pats [2] = '{4'b0110, 4'b1010};
    logic [3:0] loss [2] = '{4'd2, 4'd3};
    set_sizes(10, 50, 13, 14);
    restart();
    for (int k = 0; k < 2; k++) begin
      play_event(pats[k], 4'd1, loss[k], seen, gw, gl);
      e = exp_q.pop_front();
      checks++;
      if (!seen || gw !== e.w || gl !== e.l) begin
        failures++;
        $display("FAIL win_eat%0d: seen=%0b w=%0d l=%0d, want w=%0d l=%0d",
                 k, seen, gw, gl, e.w, e.l);
      end
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    checks++;
    if (bus.state !== 2'b11 || bus.score !== 4'd2 || bus.alive !== 4'b0011) begin
      failures++;
      $display("FAIL win_state: state=%b score=%0d alive=%b, want 11 2 0011",
               bus.state, bus.score, bus.alive);
    end
    bus.body = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.eat_valid !== 1'b0 || bus.alive !== 4'b0011) begin
        failures++;
        $display("FAIL win_no_event: cycle=%0d eat_valid=%b alive=%b, want 0 0011",
                 c, bus.eat_valid, bus.alive);
      end
    end
    bus.body        = '0;
    bus.start       = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.frame_start = 1'b0;
    checks++;
    if (bus.state !== 2'b01 || bus.alive !== 4'b1111 || bus.score !== 4'd0) begin
      failures++;
      $display("FAIL win_start_frame: state=%b alive=%b score=%0d, want 01 1111 0",
               bus.state, bus.alive, bus.score);
    end
  endtask

  task automatic test_reset_mid_play();
    bit seen;
    logic [3:0] gw, gl;
    exp_t e;
    set_sizes(10, 12, 13, 14);
    restart();
    play_event(4'b0011, 4'd1, 4'd0, seen, gw, gl);
    e = exp_q.pop_front();
    checks++;
    if (!seen || gw !== e.w || gl !== e.l) begin
      failures++;
      $display("FAIL rst_pre_eat: seen=%0b w=%0d l=%0d, want w=%0d l=%0d",
               seen, gw, gl, e.w, e.l);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.alive !== 4'b1111 || bus.score !== 4'd0 ||
        bus.eat_valid !== 1'b0 || bus.eat_winner !== 4'd0) begin
      failures++;
      $display("FAIL rst_async: state=%b alive=%b score=%0d eat_valid=%b w=%0d, want 00 1111 0 0 0",
               bus.state, bus.alive, bus.score, bus.eat_valid, bus.eat_winner);
    end
    tick();
    rst             = 1'b0;
    bus.body        = 4'b1111;
    bus.frame_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.eat_valid !== 1'b0 || bus.state !== 2'b00) begin
        failures++;
        $display("FAIL idle_ignore: cycle=%0d eat_valid=%b state=%b, want 0 00",
                 c, bus.eat_valid, bus.state);
      end
    end
    bus.body        = '0;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    bus.frame_start = 1'b0;
    bus.start       = 1'b0;
    bus.body        = '0;
    bus.size        = '0;
    test_reset();
    test_basic_eat();
    test_lowest_two();
    test_equal_sizes();
    test_over();
    test_frame_collision();
    test_win();
    test_reset_mid_play();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
